// File: rtl/interrupt_sequencer.sv
// Interrupt entry/return sequencer for the 5-stage core: latches request pulses,
// drains the pipe, redirects to the handler vector and returns to the saved PC on RTI.
//
// state  | meaning
// IDLE   | normal execution, waiting for a vector plus a pending request
// DRAIN  | fetch held while in-flight instructions retire
// ENTER  | redirect to handler vector, ack the chosen source
// ISR    | handler running; new requests only pend
// RETURN | redirect back to the saved resume PC
module interrupt_sequencer #(
  parameter int NUM_SRC   = 4,
  parameter int ADDR_W    = 32,
  parameter int DRAIN_CYC = 3,
  localparam int ID_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int CNT_W    = $clog2(DRAIN_CYC + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               rsi_ex,
  input  logic [ADDR_W-1:0]  rsi_vec,
  input  logic               rti_ex,
  input  logic [ADDR_W-1:0]  fetch_pc,
  output logic               stall_fetch,
  output logic               flush,
  output logic               redirect_valid,
  output logic [ADDR_W-1:0]  redirect_pc,
  output logic               in_isr,
  output logic [NUM_SRC-1:0] irq_ack,
  output logic [ID_W-1:0]    irq_id
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ENTER,
    S_ISR,
    S_RETURN
  } state_t;

  state_t             state, state_nx;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] low_onehot;
  logic [ID_W-1:0]    low_idx;
  logic [ADDR_W-1:0]  vec;
  logic [ADDR_W-1:0]  epc;
  logic               vec_valid;
  logic [CNT_W-1:0]   cnt;

  // Lowest index wins: isolate the least significant set bit.
  assign low_onehot = pending & (~pending + NUM_SRC'(1));

  always_comb begin
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = i[ID_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (vec_valid && (|pending)) state_nx = S_DRAIN;
      S_DRAIN:  if (cnt == '0) state_nx = S_ENTER;
      S_ENTER:  state_nx = S_ISR;
      S_ISR:    if (rti_ex) state_nx = S_RETURN;
      S_RETURN: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    stall_fetch    = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    irq_ack        = '0;
    case (state)
      S_DRAIN: stall_fetch = 1'b1;
      S_ENTER: begin
        stall_fetch    = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = vec;
        irq_ack        = low_onehot;
      end
      S_RETURN: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = epc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      vec       <= '0;
      vec_valid <= 1'b0;
      epc       <= '0;
      irq_id    <= '0;
      in_isr    <= 1'b0;
      cnt       <= '0;
    end else begin
      // A fresh pulse on the source acked this cycle must survive the clear.
      pending <= (pending & ~irq_ack) | irq_req;
      if (rsi_ex) begin
        vec       <= rsi_vec;
        vec_valid <= 1'b1;
      end
      if (state == S_IDLE && state_nx == S_DRAIN)
        cnt <= CNT_W'(DRAIN_CYC - 1);
      else if (state == S_DRAIN && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      // Late branches may still move fetch_pc during the drain; keep only the last one.
      if (state == S_DRAIN && cnt == '0)
        epc <= fetch_pc;
      if (state == S_ENTER) begin
        irq_id <= low_idx;
        in_isr <= 1'b1;
      end
      if (state == S_RETURN)
        in_isr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized and directed bench for interrupt_sequencer against a cycle-timeline
// model of entry/return scheduling.
module tb_interrupt_sequencer;
  localparam int DRAIN_CYC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq_req;
  logic        rsi_ex;
  logic [31:0] rsi_vec;
  logic        rti_ex;
  logic [31:0] fetch_pc;
  logic        stall_fetch, flush, redirect_valid, in_isr;
  logic [31:0] redirect_pc;
  logic [3:0]  irq_ack;
  logic [1:0]  irq_id;

  interrupt_sequencer #(.NUM_SRC(4), .ADDR_W(32), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .rsi_ex(rsi_ex), .rsi_vec(rsi_vec),
    .rti_ex(rti_ex), .fetch_pc(fetch_pc), .stall_fetch(stall_fetch), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .in_isr(in_isr),
    .irq_ack(irq_ack), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return 4'b0001 << i;
    return 4'b0000;
  endfunction

  function automatic logic [1:0] index_of(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Model: cycle numbers of the scheduled entry and return, plus architectural registers.
  int          cyc = 0;
  int          entry_cyc = -1;
  int          ret_cyc = -1;
  bit          in_h = 1'b0;
  bit          vec_v = 1'b0;
  logic [3:0]  pend = '0;
  logic [31:0] m_vec = '0;
  logic [31:0] m_epc = '0;
  logic [1:0]  m_id = '0;

  always @(posedge clk) begin
    int prev;
    logic [3:0] ack;
    bit waiting, idle_prev, isr_prev;
    prev = cyc;
    cyc = cyc + 1;
    if (!rst_n) begin
      pend = '0; m_vec = '0; m_epc = '0; vec_v = 1'b0; m_id = '0;
      in_h = 1'b0; entry_cyc = -1; ret_cyc = -1;
    end else begin
      waiting   = (entry_cyc >= prev);
      idle_prev = !waiting && !in_h;
      isr_prev  = in_h && !waiting && (ret_cyc != prev);
      ack = (prev == entry_cyc) ? lowest(pend) : 4'b0000;
      if (prev == entry_cyc - 1) m_epc = fetch_pc;
      if (prev == entry_cyc) begin
        m_id = index_of(ack);
        in_h = 1'b1;
      end
      if (prev == ret_cyc) in_h = 1'b0;
      if (idle_prev && vec_v && pend != 4'b0000) entry_cyc = prev + DRAIN_CYC + 1;
      if (isr_prev && rti_ex) ret_cyc = prev + 1;
      pend = (pend & ~ack) | irq_req;
      if (rsi_ex) begin
        m_vec = rsi_vec;
        vec_v = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit enter, ret, stall;
      enter = (cyc == entry_cyc);
      ret   = (cyc == ret_cyc);
      stall = (entry_cyc >= cyc) && (entry_cyc - DRAIN_CYC <= cyc);
      chk("stall_fetch", stall_fetch, stall);
      chk("flush", flush, enter || ret);
      chk("redirect_valid", redirect_valid, enter || ret);
      chk("redirect_pc", redirect_pc, enter ? m_vec : (ret ? m_epc : 32'h0));
      chk("in_isr", in_isr, in_h);
      chk("irq_ack", irq_ack, enter ? lowest(pend) : 4'b0000);
      chk("irq_id", irq_id, m_id);
    end
  end

  task automatic wait_redirect(input string name, output logic [3:0] ack, output logic [31:0] pc);
    bit hit = 1'b0;
    ack = '0;
    pc = '0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (redirect_valid) begin
        hit = 1'b1;
        ack = irq_ack;
        pc = redirect_pc;
      end
    end
    chk({name, "_redirect_seen"}, hit, 1'b1);
  endtask

  initial begin
    logic [3:0]  ack;
    logic [31:0] pc;
    int nstall;
    bit hit;
    rst_n = 1'b0; irq_req = '0; rsi_ex = 1'b0; rsi_vec = '0; rti_ex = 1'b0;
    fetch_pc = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_stall", stall_fetch, 1'b0);
    chk("reset_redirect", redirect_valid, 1'b0);
    chk("reset_ack", irq_ack, 4'b0000);
    rst_n = 1'b1;

    // No vector yet: request only pends, then RSI releases it.
    irq_req = 4'b0001;
    @(negedge clk); irq_req = '0;
    nstall = 0;
    repeat (6) begin @(negedge clk); nstall += int'(stall_fetch); end
    chk("t1_no_stall", nstall, 0);
    rsi_ex = 1'b1; rsi_vec = 32'h200;
    @(negedge clk); rsi_ex = 1'b0;
    wait_redirect("t1", ack, pc);
    chk("t1_held_ack", ack, 4'b0001);
    chk("t1_vec", pc, 32'h200);
    @(negedge clk); rti_ex = 1'b1;
    @(negedge clk); rti_ex = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Entry for src2 with vector 0x100.
    rsi_ex = 1'b1; rsi_vec = 32'h100; irq_req = 4'b0100;
    @(negedge clk); rsi_ex = 1'b0; irq_req = '0;
    nstall = 0; hit = 1'b0; ack = '0; pc = '0;
    for (int i = 0; i < 12 && !hit; i++) begin
      @(negedge clk);
      if (stall_fetch) nstall++;
      if (redirect_valid) begin hit = 1'b1; ack = irq_ack; pc = redirect_pc; end
    end
    chk("t2_hit", hit, 1'b1);
    chk("t2_stall_cycles", nstall, 4);
    chk("t2_ack", ack, 4'b0100);
    chk("t2_pc", pc, 32'h100);
    @(negedge clk);
    chk("t2_id", irq_id, 2'd2);
    chk("t2_in_isr", in_isr, 1'b1);
    chk("t2_isr_nostall", stall_fetch, 1'b0);

    // Return to saved PC.
    rti_ex = 1'b1;
    @(negedge clk); rti_ex = 1'b0;
    chk("t3_redirect", redirect_valid, 1'b1);
    chk("t3_pc", redirect_pc, 32'h40);
    chk("t3_flush", flush, 1'b1);
    @(negedge clk);
    chk("t3_in_isr", in_isr, 1'b0);
    chk("t3_idle_stall", stall_fetch, 1'b0);
    @(negedge clk);
    chk("t3_stay_idle", stall_fetch, 1'b0);

    // Two simultaneous sources: src1 first, src3 right after the return.
    irq_req = 4'b1010;
    @(negedge clk); irq_req = '0;
    wait_redirect("t4a", ack, pc);
    chk("t4_first_ack", ack, 4'b0010);
    @(negedge clk); rti_ex = 1'b1;
    @(negedge clk); rti_ex = 1'b0;
    chk("t4_return", redirect_valid, 1'b1);
    @(negedge clk);
    chk("t4_idle_gap", stall_fetch, 1'b0);
    @(negedge clk);
    chk("t4_drain_src3", stall_fetch, 1'b1);
    wait_redirect("t4b", ack, pc);
    chk("t4_second_ack", ack, 4'b1000);

    // Request arriving together with RTI must not be lost.
    @(negedge clk); irq_req = 4'b0001; rti_ex = 1'b1;
    @(negedge clk); irq_req = '0; rti_ex = 1'b0;
    chk("t5_return", redirect_valid, 1'b1);
    @(negedge clk);
    chk("t5_idle", stall_fetch, 1'b0);
    @(negedge clk);
    chk("t5_drain", stall_fetch, 1'b1);
    wait_redirect("t5", ack, pc);
    chk("t5_ack", ack, 4'b0001);
    @(negedge clk); rti_ex = 1'b1;
    @(negedge clk); rti_ex = 1'b0;

    // Reset during drain clears everything including the vector.
    @(negedge clk); irq_req = 4'b0100;
    @(negedge clk); irq_req = '0;
    @(negedge clk);
    chk("t6_draining", stall_fetch, 1'b1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("t6_stall", stall_fetch, 1'b0);
    chk("t6_redirect", redirect_valid, 1'b0);
    chk("t6_in_isr", in_isr, 1'b0);
    chk("t6_id", irq_id, 2'd0);
    irq_req = 4'b0001;
    @(negedge clk); irq_req = '0;
    nstall = 0;
    repeat (8) begin @(negedge clk); nstall += int'(stall_fetch); end
    chk("t6_no_service", nstall, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      irq_req  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      rsi_ex   = ($urandom_range(0, 15) == 0);
      rsi_vec  = $urandom;
      rti_ex   = ($urandom_range(0, 5) == 0);
      fetch_pc = $urandom;
      rst_n    = ($urandom_range(0, 399) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; irq_req = '0; rsi_ex = 1'b0; rti_ex = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
